// File: rtl/rv16_fetch_unit.sv
// rv16_fetch_unit: instruction fetch stage. Issues one outstanding word-aligned
// request at a time, buffers returned words with their PC in a small prefetch
// FIFO and presents the FIFO head downstream. Flush / pc_update redirect the
// stream; a response still in flight at a redirect is discarded (DROP state).
module rv16_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_req,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_fetch_data,
  output logic        o_fetch_valid,
  output logic [31:0] o_pc,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_pc_update,
  input  logic [31:0] i_next_pc
);

  localparam int              PW       = $clog2(DEPTH);
  localparam logic [PW:0]     CNT_FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,   // may request (when the FIFO has room)
    ST_WAIT = 2'd1,   // granted, response will be pushed
    ST_DROP = 2'd2    // granted before a redirect, response will be discarded
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_fetch_pc, w_fetch_pc_nxt;
  logic          r_started;
  logic [31:0]   r_mem_data [DEPTH];
  logic [31:0]   r_mem_pc   [DEPTH];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [PW:0]   r_count;
  logic [31:0]   r_last_data, r_last_pc;

  logic          w_redirect, w_handshake, w_push, w_pop;
  logic [31:0]   w_target;
  logic [1:0]    w_unused_next_pc_lsb;

  assign w_unused_next_pc_lsb = i_next_pc[1:0];

  assign w_redirect  = i_flush | i_pc_update;
  assign w_target    = i_pc_update ? {i_next_pc[31:2], 2'b00} : r_fetch_pc;

  // Nothing is outstanding in ST_REQ, so the credit rule reduces to FIFO room.
  assign o_imem_req  = r_started && (r_state == ST_REQ) && (r_count < CNT_FULL);
  assign o_imem_addr = r_fetch_pc;
  assign w_handshake = o_imem_req & i_imem_gnt;

  // A response arriving in a redirect cycle belongs to the old stream.
  assign w_push        = (r_state == ST_WAIT) & i_imem_rvalid & ~w_redirect;
  assign o_fetch_valid = (r_count != '0);
  assign w_pop         = o_fetch_valid & ~i_stall;

  // Head comes straight from FIFO storage; when empty, the last shown head is held.
  assign o_fetch_data = o_fetch_valid ? r_mem_data[r_rd_ptr] : r_last_data;
  assign o_pc         = o_fetch_valid ? r_mem_pc[r_rd_ptr]   : r_last_pc;

  // Next-state and next fetch PC; a redirect overrides the normal advance.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    case (r_state)
      ST_REQ: begin
        if (w_handshake) begin
          w_state_nxt    = ST_WAIT;
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
        end
      end
      ST_WAIT, ST_DROP: begin
        if (i_imem_rvalid) w_state_nxt = ST_REQ;
      end
      default: w_state_nxt = ST_REQ;
    endcase
    // Anything still outstanding after this cycle must be dropped on return.
    if (w_redirect) begin
      w_fetch_pc_nxt = w_target;
      w_state_nxt    = (w_state_nxt == ST_REQ) ? ST_REQ : ST_DROP;
    end
  end

  // FSM state, fetch PC and the one-cycle request holdoff after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      r_state    <= ST_REQ;
      r_fetch_pc <= RESET_PC;
      r_started  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_started  <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  // FIFO storage; the PC of the word in flight is fetch_pc - 4 while in ST_WAIT.
  // NOTE: storage has no reset; occupancy guards every read of it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= i_imem_rdata;
      r_mem_pc[r_wr_ptr]   <= r_fetch_pc - 32'd4;
    end
  end

  // Remember the currently shown head so outputs hold while the FIFO is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_data <= '0;
      r_last_pc   <= '0;
    end else if (o_fetch_valid) begin
      r_last_data <= r_mem_data[r_rd_ptr];
      r_last_pc   <= r_mem_pc[r_rd_ptr];
    end
  end

  // Protocol checks.
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(w_push && (r_count == CNT_FULL)));
  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (rst)
    i_imem_rvalid |-> (r_state != ST_REQ));
  a_addr_aligned: assert property (@(posedge clk) disable iff (rst)
    o_imem_req |-> (o_imem_addr[1:0] == 2'b00));

endmodule

// File: tb/tb_rv16_fetch_unit.sv
// tb_rv16_fetch_unit: memory responder with random grant/latency, directed
// scenarios followed by random stall/redirect traffic. A reference model of the
// instruction stream (target, target+4, ... restarting on every redirect or
// reset) feeds an expectation queue that a monitor pops on each consumption.
module tb_rv16_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] o_imem_addr;
  logic        o_imem_req;
  logic        i_imem_gnt    = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata  = '0;
  logic [31:0] o_fetch_data;
  logic        o_fetch_valid;
  logic [31:0] o_pc;
  logic        i_stall     = 1'b0;
  logic        i_flush     = 1'b0;
  logic        i_pc_update = 1'b0;
  logic [31:0] i_next_pc   = '0;

  rv16_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .o_imem_addr  (o_imem_addr),
    .o_imem_req   (o_imem_req),
    .i_imem_gnt   (i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid),
    .i_imem_rdata (i_imem_rdata),
    .o_fetch_data (o_fetch_data),
    .o_fetch_valid(o_fetch_valid),
    .o_pc         (o_pc),
    .i_stall      (i_stall),
    .i_flush      (i_flush),
    .i_pc_update  (i_pc_update),
    .i_next_pc    (i_next_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  // ---------------- memory responder ----------------
  int   gnt_pct = 100;
  int   lat_lo  = 0;
  int   lat_hi  = 0;
  bit   gnt_low = 1'b0;
  bit   late_rv = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_dly  = 0;

  always begin
    @(negedge clk);
    if (rst) begin
      pend          = 1'b0;
      i_imem_gnt    = 1'b0;
      i_imem_rvalid = late_rv;
      i_imem_rdata  = 32'hDEAD_BEEF;
    end else begin
      if (pend && pend_dly == 0) begin
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = mem_word(pend_addr);
        pend          = 1'b0;
      end else begin
        i_imem_rvalid = 1'b0;
        if (pend) pend_dly--;
      end
      i_imem_gnt = !gnt_low && ($urandom_range(99, 0) < gnt_pct);
    end
    #4;
    if (!rst && o_imem_req && i_imem_gnt) begin
      pend      = 1'b1;
      pend_addr = o_imem_addr;
      pend_dly  = int'($urandom_range(lat_hi, lat_lo));
    end
  end

  // ---------------- reference model + monitor ----------------
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] exp_next  = RESET_PC;
  logic [31:0] model_fpc = RESET_PC;
  int          n_hs       = 0;
  int          n_consumed = 0;

  task automatic restart(input logic [31:0] t);
    exp_q.delete();
    exp_next = t;
  endtask

  always begin : monitor
    logic        redir;
    logic        prev_wait;
    logic [31:0] prev_addr;
    logic [31:0] tgt;
    exp_t        e;
    prev_wait = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        model_fpc = RESET_PC;
        restart(RESET_PC);
        prev_wait = 1'b0;
      end else begin
        redir = i_flush || i_pc_update;
        if (prev_wait && o_imem_req) check("addr_stable", o_imem_addr, prev_addr);
        if (o_imem_req && i_imem_gnt) begin
          n_hs++;
          check("req_addr", o_imem_addr, model_fpc);
        end
        if (o_fetch_valid && !i_stall) begin
          while (exp_q.size() < 2) begin
            exp_q.push_back('{exp_next, mem_word(exp_next)});
            exp_next += 32'd4;
          end
          e = exp_q.pop_front();
          n_consumed++;
          check("fetch_pc", o_pc, e.pc);
          check("fetch_data", o_fetch_data, e.data);
        end
        if (redir) begin
          tgt       = i_pc_update ? {i_next_pc[31:2], 2'b00} : model_fpc;
          model_fpc = tgt;
          restart(tgt);
        end else if (o_imem_req && i_imem_gnt) begin
          model_fpc += 32'd4;
        end
        prev_wait = o_imem_req && !i_imem_gnt && !redir;
        prev_addr = o_imem_addr;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_hs(input string name);
    int snap;
    int k;
    snap = n_hs;
    k    = 0;
    while (n_hs == snap && k < 50) begin
      tick();
      k++;
    end
    check(name, 32'(n_hs != snap), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(o_imem_req),    32'd0);
    check({tag, "_addr"},  o_imem_addr,        RESET_PC);
    check({tag, "_valid"}, 32'(o_fetch_valid), 32'd0);
    check({tag, "_data"},  o_fetch_data,       32'd0);
    check({tag, "_pc"},    o_pc,               32'd0);
  endtask

  initial begin
    int snap;
    int r;

    // 1: reset state, first request one cycle after release, sequential stream
    #22;
    check_reset_outputs("rst");
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("first_req_holdoff", 32'(o_imem_req), 32'd0);
    @(posedge clk);
    #1;
    check("first_req", 32'(o_imem_req), 32'd1);
    check("first_addr", o_imem_addr, RESET_PC);
    snap = n_consumed;
    tick(20);
    check("t1_progress", 32'(n_consumed - snap >= 6), 32'd1);

    // 2: stall with a redirect -> exactly DEPTH fetches, then request idles
    i_pc_update = 1'b1;
    i_next_pc   = 32'h0000_0200;
    i_stall     = 1'b1;
    tick();
    i_pc_update = 1'b0;
    snap = n_hs;
    tick(12);
    check("t2_fill_count", 32'(n_hs - snap), 32'(DEPTH));
    check("t2_req_idle", 32'(o_imem_req), 32'd0);
    check("t2_valid", 32'(o_fetch_valid), 32'd1);
    i_stall = 1'b0;
    tick(20);

    // 3: redirect while a response is in flight
    lat_lo = 3;
    lat_hi = 3;
    wait_hs("t3_grant");
    i_pc_update = 1'b1;
    i_next_pc   = 32'h0000_0100;
    tick();
    i_pc_update = 1'b0;
    tick(25);

    // 4: grant withheld -> address held, no handshake; then flush mid-wait
    lat_lo  = 0;
    lat_hi  = 0;
    gnt_low = 1'b1;
    tick();
    snap = n_hs;
    tick(5);
    check("t4_no_grant", 32'(n_hs - snap), 32'd0);
    check("t4_req_held", 32'(o_imem_req), 32'd1);
    gnt_low = 1'b0;
    lat_lo  = 4;
    lat_hi  = 4;
    wait_hs("t4_grant");
    tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    tick(25);

    // 5: address wrap and unaligned redirect target
    lat_lo = 0;
    lat_hi = 0;
    i_pc_update = 1'b1;
    i_next_pc   = 32'hFFFF_FFFC;
    tick();
    i_pc_update = 1'b0;
    tick(12);
    i_pc_update = 1'b1;
    i_next_pc   = 32'h0000_0103;
    tick();
    i_pc_update = 1'b0;
    tick(12);

    // 6: reset in the middle of a wait, late response during reset
    lat_lo = 3;
    lat_hi = 3;
    wait_hs("t6_grant");
    #2 rst = 1'b1;
    late_rv = 1'b1;
    #1 check_reset_outputs("t6_rst");
    tick(2);
    late_rv = 1'b0;
    tick();
    #2 rst = 1'b0;
    tick(15);

    // random traffic
    gnt_pct = 60;
    lat_lo  = 0;
    lat_hi  = 3;
    snap    = n_consumed;
    for (int i = 0; i < 1500; i++) begin
      tick();
      i_stall     = ($urandom_range(99, 0) < 30);
      i_flush     = 1'b0;
      i_pc_update = 1'b0;
      r = int'($urandom_range(99, 0));
      if (r < 1) begin
        i_flush = 1'b1;
      end else if (r < 3) begin
        i_pc_update = 1'b1;
        i_flush     = (r == 2);
        case ($urandom_range(2, 0))
          0:       i_next_pc = $urandom;
          1:       i_next_pc = 32'hFFFF_FFF4;
          default: i_next_pc = 32'h0000_1000 | $urandom_range(3, 0);
        endcase
      end
    end
    tick();
    i_stall     = 1'b0;
    i_flush     = 1'b0;
    i_pc_update = 1'b0;
    tick(10);
    check("rand_progress", 32'(n_consumed - snap >= 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
